// File: rtl/key_entry_sequencer.sv
// key_entry_sequencer: turns debounced keypad codes into digit/operator/equals/clear
// strobes for the operand accumulator, and requests/awaits the arithmetic result.
// Latency 1 cycle from key_valid/calc_done to every output; no backpressure (keys are strobes).
// Ports: clk, rst (sync, active-high); key_valid/key_code in; calc_done in (result ready);
//   digits/new_number/digit_number/op_number (digit events), op_received/operation (operator),
//   calc_start, clear_pulse, key_error out. All outputs registered.
module key_entry_sequencer #(
  parameter int         MAX_DIGITS = 4,
  parameter logic [3:0] KEY_ADD    = 4'hA,
  parameter logic [3:0] KEY_SUB    = 4'hB,
  parameter logic [3:0] KEY_MUL    = 4'hC,
  parameter logic [3:0] KEY_DIV    = 4'hD,
  parameter logic [3:0] KEY_EQ     = 4'hE,
  parameter logic [3:0] KEY_CLR    = 4'hF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       calc_done,
  output logic [3:0] digits,
  output logic       new_number,
  output logic       op_received,
  output logic       op_number,
  output logic [1:0] digit_number,
  output logic [1:0] operation,
  output logic       calc_start,
  output logic       clear_pulse,
  output logic       key_error
);

  typedef enum logic [1:0] {S_OP1, S_OP2, S_CALC, S_RESULT} state_t;

  localparam logic [2:0] MAX_CNT = 3'(MAX_DIGITS);

  state_t     state_q, state_d;
  logic [2:0] count_q, count_d;

  logic [3:0] digits_d;
  logic       op_number_d;
  logic [1:0] digit_number_d, operation_d;
  logic       new_number_d, op_received_d, calc_start_d, clear_pulse_d, key_error_d;

  // Key classification. Clear and equals are decoded first so they can never be
  // taken as digits even if the parameters were overlapped.
  logic       is_clr, is_eq, is_op, is_digit;
  logic [1:0] op_code;

  always_comb begin
    is_clr   = (key_code == KEY_CLR);
    is_eq    = (key_code == KEY_EQ) && !is_clr;
    is_op    = !is_clr && !is_eq &&
               ((key_code == KEY_ADD) || (key_code == KEY_SUB) ||
                (key_code == KEY_MUL) || (key_code == KEY_DIV));
    is_digit = !is_clr && !is_eq && !is_op && (key_code <= 4'd9);
    op_code  = 2'd0;
    if (key_code == KEY_SUB) op_code = 2'd1;
    if (key_code == KEY_MUL) op_code = 2'd2;
    if (key_code == KEY_DIV) op_code = 2'd3;
  end

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    digits_d       = digits;
    op_number_d    = op_number;
    digit_number_d = digit_number;
    operation_d    = operation;
    new_number_d   = 1'b0;
    op_received_d  = 1'b0;
    calc_start_d   = 1'b0;
    clear_pulse_d  = 1'b0;
    key_error_d    = 1'b0;

    if (key_valid && is_clr) begin
      // Clear wins in every state, including a simultaneous calc_done.
      clear_pulse_d = 1'b1;
      state_d       = S_OP1;
      count_d       = 3'd0;
      op_number_d   = 1'b0;
      operation_d   = 2'd0;
    end else begin
      case (state_q)
        S_OP1, S_OP2: begin
          if (key_valid) begin
            if (is_digit) begin
              if (count_q < MAX_CNT) begin
                new_number_d   = 1'b1;
                digits_d       = key_code;
                op_number_d    = (state_q == S_OP2);
                digit_number_d = count_q[1:0];
                count_d        = count_q + 3'd1;
              end else begin
                key_error_d = 1'b1;
              end
            end else if (is_op) begin
              // Op1 needs at least one digit; in op2 the operator may only be
              // replaced before any op2 digit (no chained expressions).
              if ((state_q == S_OP1 && count_q != 3'd0) ||
                  (state_q == S_OP2 && count_q == 3'd0)) begin
                op_received_d = 1'b1;
                operation_d   = op_code;
                op_number_d   = 1'b1;
                count_d       = 3'd0;
                state_d       = S_OP2;
              end else begin
                key_error_d = 1'b1;
              end
            end else if (is_eq && state_q == S_OP2 && count_q != 3'd0) begin
              calc_start_d = 1'b1;
              state_d      = S_CALC;
            end else begin
              key_error_d = 1'b1;
            end
          end
        end
        S_CALC: begin
          if (calc_done) state_d = S_RESULT;
          if (key_valid) key_error_d = 1'b1;
        end
        default: begin  // S_RESULT: only clear is accepted
          if (key_valid) key_error_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_OP1;
      count_q      <= 3'd0;
      digits       <= 4'd0;
      op_number    <= 1'b0;
      digit_number <= 2'd0;
      operation    <= 2'd0;
      new_number   <= 1'b0;
      op_received  <= 1'b0;
      calc_start   <= 1'b0;
      clear_pulse  <= 1'b0;
      key_error    <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      digits       <= digits_d;
      op_number    <= op_number_d;
      digit_number <= digit_number_d;
      operation    <= operation_d;
      new_number   <= new_number_d;
      op_received  <= op_received_d;
      calc_start   <= calc_start_d;
      clear_pulse  <= clear_pulse_d;
      key_error    <= key_error_d;
    end
  end

endmodule

// File: tb/tb_key_entry_sequencer.sv
// Testbench for key_entry_sequencer: directed scenarios followed by random keys,
// every output compared each cycle against a behavioural model of the keypad rules.
module tb_key_entry_sequencer;

  localparam int MAXD = 4;

  logic       clk = 1'b0;
  logic       rst, key_valid, calc_done;
  logic [3:0] key_code;
  logic [3:0] digits;
  logic       new_number, op_received, op_number, calc_start, clear_pulse, key_error;
  logic [1:0] digit_number, operation;

  always #5 clk = ~clk;

  key_entry_sequencer #(.MAX_DIGITS(MAXD)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .calc_done(calc_done), .digits(digits), .new_number(new_number),
    .op_received(op_received), .op_number(op_number), .digit_number(digit_number),
    .operation(operation), .calc_start(calc_start), .clear_pulse(clear_pulse),
    .key_error(key_error)
  );

  int checks = 0;
  int errors = 0;
  string phase = "init";

  // Reference model: which operand is being typed, digits typed so far,
  // whether a result is pending or being shown, plus the expected outputs.
  int         m_cur, m_cnt;
  bit         m_wait, m_shown;
  logic [3:0] e_digits;
  logic       e_opnum, e_nn, e_opr, e_cs, e_clr, e_err;
  logic [1:0] e_dnum, e_oper;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s/%s: observed %0h expected %0h", phase, tag, got, exp);
    end
  endtask

  task automatic model(input logic r, input logic kv, input logic [3:0] code, input logic cd);
    int  c;
    bit  busy, shown;
    c = int'(code);
    e_nn = 0; e_opr = 0; e_cs = 0; e_clr = 0; e_err = 0;
    if (r) begin
      m_cur = 0; m_cnt = 0; m_wait = 0; m_shown = 0;
      e_digits = 4'd0; e_opnum = 1'b0; e_dnum = 2'd0; e_oper = 2'd0;
    end else begin
      busy  = m_wait;
      shown = m_shown;
      if (cd && busy) begin m_wait = 0; m_shown = 1; end
      if (kv) begin
        if (c == 15) begin
          e_clr = 1; m_cur = 0; m_cnt = 0; m_wait = 0; m_shown = 0;
          e_opnum = 1'b0; e_oper = 2'd0;
        end else if (busy || shown) begin
          e_err = 1;
        end else if (c <= 9) begin
          if (m_cnt < MAXD) begin
            e_nn = 1; e_digits = code; e_opnum = 1'(m_cur); e_dnum = 2'(m_cnt);
            m_cnt++;
          end else e_err = 1;
        end else if (c >= 10 && c <= 13) begin
          if ((m_cur == 0 && m_cnt > 0) || (m_cur == 1 && m_cnt == 0)) begin
            e_opr = 1; e_oper = 2'(c - 10); e_opnum = 1'b1; m_cur = 1; m_cnt = 0;
          end else e_err = 1;
        end else begin  // equals
          if (m_cur == 1 && m_cnt > 0) begin
            e_cs = 1; m_wait = 1;
          end else e_err = 1;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("digits",       digits,              e_digits);
    chk("new_number",   4'(new_number),      4'(e_nn));
    chk("op_received",  4'(op_received),     4'(e_opr));
    chk("op_number",    4'(op_number),       4'(e_opnum));
    chk("digit_number", 4'(digit_number),    4'(e_dnum));
    chk("operation",    4'(operation),       4'(e_oper));
    chk("calc_start",   4'(calc_start),      4'(e_cs));
    chk("clear_pulse",  4'(clear_pulse),     4'(e_clr));
    chk("key_error",    4'(key_error),       4'(e_err));
  endtask

  // Called at a falling edge: drive, let one rising edge pass, check at the next falling edge.
  task automatic step(input logic r, input logic kv, input logic [3:0] code, input logic cd);
    rst = r; key_valid = kv; key_code = code; calc_done = cd;
    model(r, kv, code, cd);
    @(negedge clk);
    check_all();
    rst = 1'b0; key_valid = 1'b0; calc_done = 1'b0;
  endtask

  task automatic key(input logic [3:0] code);
    step(1'b0, 1'b1, code, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 4'd0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; key_valid = 1'b0; key_code = 4'd0; calc_done = 1'b0;
    @(negedge clk);

    phase = "reset";
    do_reset(); idle();

    phase = "basic";
    key(4'd1); key(4'd2); key(4'hA); key(4'd3); key(4'hE); idle();

    phase = "maxdig";
    do_reset();
    for (int i = 0; i < 5; i++) key(4'd9);
    idle();

    phase = "badop";
    do_reset(); key(4'hA); key(4'hE); key(4'd1); key(4'hA); key(4'hE); key(4'hB); idle();

    phase = "opreplace";
    do_reset(); key(4'd5); key(4'hA); key(4'hB); key(4'hC); key(4'd2); key(4'hD);

    phase = "calc";
    key(4'hE); key(4'd1); key(4'hA); idle();
    step(1'b0, 1'b0, 4'd0, 1'b1);
    key(4'd3); key(4'hE); key(4'hF); key(4'd7);

    phase = "samecycle";
    key(4'hA); key(4'd8); key(4'hE);
    step(1'b0, 1'b1, 4'd4, 1'b1);
    key(4'hF); key(4'd6); key(4'hB); key(4'd6); key(4'hE);
    step(1'b0, 1'b1, 4'hF, 1'b1);
    key(4'd2); key(4'hC); key(4'd2); key(4'hE);
    key(4'hF); step(1'b0, 1'b0, 4'd0, 1'b1); key(4'd1);

    phase = "midreset";
    do_reset(); key(4'd1); key(4'hA); key(4'd2);
    do_reset(); key(4'd3); idle();

    phase = "random";
    for (int n = 0; n < 600; n++) begin
      logic       r, kv, cd;
      logic [3:0] code;
      r    = ($urandom_range(0, 49) == 0);
      kv   = ($urandom_range(0, 2) != 0);
      code = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 9))
                                         : 4'($urandom_range(10, 15));
      cd   = ($urandom_range(0, 3) == 0);
      step(r, kv, code, cd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
